// File: rtl/hdmi_fetch_ctrl.sv
// hdmi_fetch_ctrl: frame-buffer fetch scheduler for the HDMI output path.
// Turns the line/chunk/done pulses from hdmi_core into chunked burst-read
// commands for the memory read master. It tracks the line address, the
// offset within the line, the words left on the line and the chunk credits.
// Optional sticky status (underflow, overrun, frame counter) is built only
// when the macro HDMI_FETCH_STATUS_EN is defined; otherwise those outputs
// are tied to zero.
module hdmi_fetch_ctrl #(
    parameter int CHUNK_WORDS = 64,
    parameter int PREFETCH    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] fb_base,
    input  logic [10:0] hres,
    input  logic        num_bytes_per_pixel,
    input  logic        read_go,
    input  logic        read_next_line,
    input  logic        read_next_chunk,
    input  logic        read_done,
    input  logic        rd_ack,
    input  logic        rd_cmplt,
    input  logic        fifo_empty,
    input  logic        ve,
    input  logic        clr_status,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    output logic [7:0]  rd_len,
    output logic        frame_active,
    output logic        underflow,
    output logic        overrun,
    output logic [15:0] frame_cnt
);

    localparam logic [7:0] CHUNK_LEN   = 8'(CHUNK_WORDS);
    localparam logic [1:0] PREFETCH_CR = 2'(PREFETCH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_BUSY,
        ST_WAIT
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] line_addr, line_addr_nxt;
    logic [31:0] chunk_off, chunk_off_nxt;
    logic [10:0] remaining, remaining_nxt;
    logic [1:0]  credits, credits_nxt;
    logic        line_pend, line_pend_nxt;
    logic        done_pend, done_pend_nxt;

    logic [10:0] wpl;
    logic [31:0] stride;
    logic [7:0]  cur_len;
    logic [7:0]  nxt_len;
    logic        ack_fire;
    logic        do_reload;
    logic        overrun_set;
    logic        done_evt;

    // Burst length is the smaller of a full chunk and what is left on the line.
    function automatic logic [7:0] burst_len(input logic [10:0] rem);
        return (rem >= 11'(CHUNK_WORDS)) ? CHUNK_LEN : rem[7:0];
    endfunction

    // RGB565 packs two pixels per word, so an odd width rounds up one word.
    assign wpl      = num_bytes_per_pixel ? hres : ((hres >> 1) + {10'b0, hres[0]});
    assign stride   = {19'b0, wpl, 2'b00};
    assign cur_len  = burst_len(remaining);
    assign nxt_len  = burst_len(remaining_nxt);
    assign ack_fire = (state == ST_REQ) && rd_ack;

    // Next-state, address bookkeeping and credit accounting.
    always_comb begin
        state_nxt     = state;
        line_addr_nxt = line_addr;
        chunk_off_nxt = chunk_off;
        remaining_nxt = remaining;
        credits_nxt   = credits;
        line_pend_nxt = line_pend;
        done_pend_nxt = done_pend;
        do_reload     = 1'b0;
        overrun_set   = 1'b0;
        done_evt      = 1'b0;

        if (!start) begin
            state_nxt     = ST_IDLE;
            credits_nxt   = 2'd0;
            line_pend_nxt = 1'b0;
            done_pend_nxt = 1'b0;
        end else if (state == ST_IDLE) begin
            if (read_go) begin
                line_addr_nxt = fb_base;
                chunk_off_nxt = 32'd0;
                remaining_nxt = wpl;
                credits_nxt   = PREFETCH_CR;
                line_pend_nxt = 1'b0;
                done_pend_nxt = 1'b0;
                state_nxt     = ST_REQ;
            end
        end else begin
            if (ack_fire) begin
                remaining_nxt = remaining - {3'b0, cur_len};
                chunk_off_nxt = chunk_off + {22'b0, cur_len, 2'b00};
                credits_nxt   = (credits != 2'd0) ? (credits - 2'd1) : 2'd0;
            end

            if (read_next_chunk && !read_done && !read_next_line) begin
                if (ack_fire) begin
                    credits_nxt = credits;
                end else if (credits == 2'd3) begin
                    overrun_set = 1'b1;
                end else begin
                    credits_nxt = credits + 2'd1;
                end
            end

            if (read_next_line && !read_done) begin
                if ((state == ST_REQ) && !rd_ack) begin
                    line_pend_nxt = 1'b1;
                end else begin
                    do_reload = 1'b1;
                end
            end

            if (ack_fire && line_pend && !read_done) begin
                do_reload = 1'b1;
            end

            if (do_reload) begin
                line_addr_nxt = line_addr + stride;
                chunk_off_nxt = 32'd0;
                remaining_nxt = wpl;
                credits_nxt   = PREFETCH_CR;
                line_pend_nxt = 1'b0;
            end

            if (read_done) begin
                credits_nxt   = 2'd0;
                done_pend_nxt = 1'b1;
                line_pend_nxt = 1'b0;
                done_evt      = 1'b1;
            end

            case (state)
                ST_REQ: begin
                    if (rd_ack) begin
                        state_nxt = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (rd_cmplt) begin
                        if (done_pend || read_done) begin
                            state_nxt = ST_IDLE;
                        end else if ((credits != 2'd0) && (remaining != 11'd0)) begin
                            state_nxt = ST_REQ;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (done_pend || read_done) begin
                        state_nxt = ST_IDLE;
                    end else if ((credits != 2'd0) && (remaining != 11'd0)) begin
                        state_nxt = ST_REQ;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase

            if (state_nxt == ST_IDLE) begin
                done_pend_nxt = 1'b0;
                credits_nxt   = 2'd0;
            end
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            line_addr <= 32'd0;
            chunk_off <= 32'd0;
            remaining <= 11'd0;
            credits   <= 2'd0;
            line_pend <= 1'b0;
            done_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            line_addr <= line_addr_nxt;
            chunk_off <= chunk_off_nxt;
            remaining <= remaining_nxt;
            credits   <= credits_nxt;
            line_pend <= line_pend_nxt;
            done_pend <= done_pend_nxt;
        end
    end

    // Command outputs are registered from next-state values so they hold steady through REQ.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_req       <= 1'b0;
            rd_addr      <= 32'd0;
            rd_len       <= 8'd0;
            frame_active <= 1'b0;
        end else begin
            rd_req       <= (state_nxt == ST_REQ);
            rd_addr      <= (state_nxt == ST_REQ) ? (line_addr_nxt + chunk_off_nxt) : 32'd0;
            rd_len       <= (state_nxt == ST_REQ) ? nxt_len : 8'd0;
            frame_active <= (state_nxt != ST_IDLE);
        end
    end

`ifdef HDMI_FETCH_STATUS_EN
    // Sticky status flags and completed-frame counter; a new set beats a clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            underflow <= 1'b0;
            overrun   <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            if (ve && fifo_empty) begin
                underflow <= 1'b1;
            end else if (clr_status) begin
                underflow <= 1'b0;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clr_status) begin
                overrun <= 1'b0;
            end
            if (done_evt) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`else
    logic status_unused;
    assign status_unused = ^{clr_status, fifo_empty, ve, overrun_set, done_evt};
    assign underflow     = 1'b0;
    assign overrun       = 1'b0;
    assign frame_cnt     = 16'd0;
`endif

endmodule

// File: doc/hdmi_fetch_ctrl.md
# hdmi_fetch_ctrl

Frame-buffer fetch scheduler for the HDMI output path. Consumes the `read_go` / `read_next_line` / `read_next_chunk` / `read_done` pulses from `hdmi_core` and issues chunked burst-read commands to the memory read master, which fills the pixel FIFO that feeds `hdmi_core.color`. It tracks frame and line addresses, the words remaining per line, and the outstanding chunk credits, and keeps optional sticky status.

## Interface
- `CHUNK_WORDS`, default 64: maximum 32-bit words per burst. Must be a power of 2, ≤255.
- `PREFETCH`, default 2: chunk credits granted at the start of each line (1..3).
- `clock` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: enable. When 0, the FSM is forced to IDLE and credits are cleared.
- `fb_base` in 32: frame-buffer byte address, 4-byte aligned. Sampled on `read_go`.
- `hres` in 11: horizontal resolution (640/800/1280).
- `num_bytes_per_pixel` in 1: 1 = RGB888 (1 word/pixel), 0 = RGB565 (2 pixels/word).
- `read_go`, `read_next_line`, `read_next_chunk`, `read_done` in 1 each: single-cycle pulses from `hdmi_core`.
- `rd_ack` in 1: memory master accepted the command.
- `rd_cmplt` in 1: last beat of the accepted burst was written to the FIFO.
- `fifo_empty` in 1: pixel FIFO empty.
- `ve` in 1: video-enable from `hdmi_core`.
- `clr_status` in 1: clears the sticky flags.
- `rd_req` out 1: command valid.
- `rd_addr` out 32: burst byte address.
- `rd_len` out 8: burst length in words, 1..`CHUNK_WORDS`.
- `frame_active` out 1: a frame fetch is in progress.
- `underflow` out 1: sticky flag.
- `overrun` out 1: sticky flag.
- `frame_cnt` out 16: completed frames.

## Operation
- Words per line: `wpl = num_bytes_per_pixel ? hres : (hres+1)>>1`, 11 bits. Line stride = `wpl*4` bytes, 32-bit wrap-around add.
- Registers:
  - `line_addr` (32)
  - `chunk_off` (32, bytes)
  - `remaining` (11, words)
  - `credits` (2 bits, saturating at 3)
- States:
  - **IDLE**: outputs low. On `read_go`: `line_addr=fb_base`, `chunk_off=0`, `remaining=wpl`, `credits=PREFETCH`, `frame_active=1`, go to REQ.
  - **REQ**: `rd_req=1`, `rd_addr=line_addr+chunk_off`, `rd_len=min(CHUNK_WORDS,remaining)`. These stay stable until `rd_ack`. On `rd_ack`: `remaining-=rd_len`, `chunk_off+=rd_len*4`, `credits-=1`, go to BUSY.
  - **BUSY**: wait for `rd_cmplt`. Then go to REQ if `credits>0 && remaining>0`, otherwise to WAIT. If a frame end is pending, go to IDLE instead.
  - **WAIT**: go to REQ when `credits>0 && remaining>0`.
- `read_next_chunk`: `credits+=1`. If `credits` is already 3, it is held and `overrun` is set.
- `read_next_line`:
  - Sets `line_addr+=stride`, `chunk_off=0`, `remaining=wpl`, `credits=PREFETCH`.
  - Arriving in REQ: the load is deferred until `rd_ack`, so the held command stays intact. The ack's decrement is then superseded by the reload.
  - Arriving in BUSY: the reload applies immediately. The in-flight burst completes normally.
- `read_done`:
  - `credits=0`, `frame_cnt+=1` (wraps at 16 bits).
  - From WAIT, go to IDLE next cycle.
  - From REQ or BUSY, finish the current burst (ack, then cmplt), then go to IDLE. `frame_active` falls when IDLE is entered.
- Simultaneous `rd_ack` and `read_next_chunk`: net `credits` is unchanged.
- Events with priority:
  - `read_done` beats `read_next_line`, which beats `read_next_chunk`.
  - `read_go` outside IDLE is ignored.
- `underflow` sets when `ve && fifo_empty`.
- `clr_status` clears both sticky flags. A set condition in the same cycle wins.
- `start=0` mid-frame: synchronous return to IDLE and `rd_req` drops. The memory master must tolerate the abandoned request.

## Timing
- Reset (async, `reset_n=0`): state IDLE and every output 0, including `rd_addr`, `rd_len` and `frame_cnt`.
- `read_go` at cycle t: `rd_req=1` at t+1.
- `rd_ack` at t: `rd_req=0` at t+1.
- `rd_cmplt` at t with work pending: `rd_req=1` at t+1.
- Credit from `read_next_chunk` at t while in WAIT: `rd_req=1` at t+2.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `HDMI_FETCH_STATUS_EN` defined: `underflow`, `overrun` and `frame_cnt` are implemented as described above.
- `HDMI_FETCH_STATUS_EN` undefined:
  - Those three outputs are tied to 0, and `clr_status`, `fifo_empty` and `ve` are ignored.
  - Credit saturation still applies silently.

## Test plan
- 640-wide frame, RGB888, `fb_base=0x1000_0000`, `rd_ack`/`rd_cmplt` immediate, `read_go` pulse. Expect bursts (0x1000_0000, 64) and (0x1000_0100, 64). No third burst until `read_next_chunk`; after 8 more chunk pulses, the 10th burst is (0x1000_0900, 64) and no 11th is issued.
- `read_next_line` at hres=800, RGB565 (wpl=400, stride 0x640). The next burst is at `line_addr+0x640`, length 64. The 7th burst of the line has length 16.
- Hold `rd_ack` low for 10 cycles while `read_next_line` pulses. `rd_addr`/`rd_len` stay stable throughout; after the ack, the next burst starts the new line.
- Four `read_next_chunk` pulses with `rd_ack` stalled. `credits` saturates at 3, `overrun=1`, and `clr_status` clears it.
- `read_done` while BUSY. IDLE is entered one cycle after `rd_cmplt`, and `frame_cnt` increments 0→1.
- Assert `reset_n` low mid-REQ, asynchronously. `rd_req`, `rd_addr` and `frame_active` drop to 0 immediately without a clock edge.
